// File: rtl/dmem_access_unit.sv
// Data-memory load/store access unit: request decode, one-cycle strobe, WAIT_CYCLES read latency, held response.
// Build option: define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses instead of masking the low address bits.
module dmem_access_unit #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        D_MEM_CSN,
  output logic        D_MEM_WEN,
  output logic [3:0]  D_MEM_BE,
  output logic [31:0] D_MEM_ADDR,
  output logic [31:0] D_MEM_DOUT,
  input  logic [31:0] D_MEM_DI,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  state_t      state_r, state_n;
  logic [3:0]  cnt_r;
  logic        write_r;
  logic [2:0]  funct3_r;
  logic [1:0]  off_r;
  logic        req_ready_r, csn_r, wen_r, rsp_valid_r, rsp_err_r;
  logic [3:0]  be_r;
  logic [31:0] addr_r, dout_r, rdata_r;

  logic [1:0]  off_s;
  logic        misalign_s, illegal_s, fault_s, accept_s, wait_done_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;

  // Select the addressed lane of a read word and sign/zero-extend it.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] di);
    logic [31:0] lane;
    lane = di >> {off, 3'b000};
    case (f3)
      3'b000:  load_extend = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_extend = {{16{lane[15]}}, lane[15:0]};
      3'b010:  load_extend = di;
      3'b100:  load_extend = {24'h000000, lane[7:0]};
      3'b101:  load_extend = {16'h0000, lane[15:0]};
      default: load_extend = 32'h0000_0000;
    endcase
  endfunction

  // Decode the incoming request: lane offset, byte enables, replicated store data, fault.
  always_comb begin
    off_s      = 2'b00;
    misalign_s = 1'b0;
    be_s       = 4'b0000;
    wdata_s    = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        off_s   = req_addr[1:0];
        be_s    = 4'b0001 << off_s;
        wdata_s = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        off_s      = {req_addr[1], 1'b0};
        misalign_s = req_addr[0];
        be_s       = 4'b0011 << off_s;
        wdata_s    = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        off_s      = 2'b00;
        misalign_s = |req_addr[1:0];
        be_s       = 4'b1111;
        wdata_s    = req_wdata;
      end
      default: begin
        off_s   = 2'b00;
        be_s    = 4'b0000;
        wdata_s = req_wdata;
      end
    endcase
    if (req_write) begin
      illegal_s = (req_funct3 >= 3'b011);
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal_s = 1'b0;
        default:                                illegal_s = 1'b1;
      endcase
    end
`ifdef DMEM_MISALIGN_TRAP_EN
    fault_s = illegal_s | misalign_s;
`else
    fault_s = illegal_s;
`endif
  end

  // Next-state logic.
  always_comb begin
    state_n     = state_r;
    accept_s    = 1'b0;
    wait_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          state_n  = fault_s ? RESP : ACCESS;
        end else begin
          state_n = IDLE;
        end
      end
      ACCESS: state_n = write_r ? RESP : WAIT;
      WAIT: begin
        if (cnt_r == CNT_LAST) begin
          wait_done_s = 1'b1;
          state_n     = RESP;
        end else begin
          state_n = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_n = IDLE;
        end else begin
          state_n = RESP;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Request capture, wait counter, memory strobe and response registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_r       <= 4'd0;
      write_r     <= 1'b0;
      funct3_r    <= 3'b000;
      off_r       <= 2'b00;
      req_ready_r <= 1'b1;
      csn_r       <= 1'b1;
      wen_r       <= 1'b1;
      be_r        <= 4'b0000;
      addr_r      <= 32'h0000_0000;
      dout_r      <= 32'h0000_0000;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rdata_r     <= 32'h0000_0000;
    end else begin
      if (accept_s && !fault_s) begin
        write_r  <= req_write;
        funct3_r <= req_funct3;
        off_r    <= off_s;
        addr_r   <= {req_addr[31:2], 2'b00};
        dout_r   <= wdata_s;
      end
      if (state_r == WAIT && !wait_done_s) begin
        cnt_r <= cnt_r + 4'd1;
      end else begin
        cnt_r <= 4'd0;
      end
      req_ready_r <= (state_n == IDLE);
      csn_r       <= (state_n != ACCESS);
      wen_r       <= (state_n == ACCESS) ? !req_write : 1'b1;
      be_r        <= (state_n == ACCESS) ? be_s : 4'b0000;
      rsp_valid_r <= (state_n == RESP);
      // Response fields are loaded on entry to RESP and held until the handshake.
      if (state_r != RESP && state_n == RESP) begin
        rsp_err_r <= (state_r == IDLE);
        rdata_r   <= wait_done_s ? load_extend(funct3_r, off_r, D_MEM_DI) : 32'h0000_0000;
      end else if (state_n != RESP) begin
        rsp_err_r <= 1'b0;
        rdata_r   <= 32'h0000_0000;
      end else begin
        rsp_err_r <= rsp_err_r;
        rdata_r   <= rdata_r;
      end
    end
  end

  assign req_ready  = req_ready_r;
  assign D_MEM_CSN  = csn_r;
  assign D_MEM_WEN  = wen_r;
  assign D_MEM_BE   = be_r;
  assign D_MEM_ADDR = addr_r;
  assign D_MEM_DOUT = dout_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_err    = rsp_err_r;
  assign rsp_rdata  = rdata_r;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Table-driven bench for dmem_access_unit (WAIT_CYCLES=3) plus response-stall and mid-transaction reset sequences.
module tb_dmem_access_unit;

  localparam int W = 3;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        CLK, RST;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        D_MEM_CSN, D_MEM_WEN;
  logic [3:0]  D_MEM_BE;
  logic [31:0] D_MEM_ADDR, D_MEM_DOUT, D_MEM_DI;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  dmem_access_unit #(.WAIT_CYCLES(W)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .D_MEM_CSN(D_MEM_CSN), .D_MEM_WEN(D_MEM_WEN), .D_MEM_BE(D_MEM_BE),
    .D_MEM_ADDR(D_MEM_ADDR), .D_MEM_DOUT(D_MEM_DOUT), .D_MEM_DI(D_MEM_DI),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, di;
    int          acc;
    logic [3:0]  be;
    logic [31:0] maddr, dout, rdata;
    logic        err;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] di, input int acc,
                              input logic [3:0] be, input logic [31:0] maddr, input logic [31:0] dout,
                              input logic [31:0] rdata, input logic err);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.di = di; v.acc = acc;
    v.be = be; v.maddr = maddr; v.dout = dout; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  function automatic vec_t mk_fault(input logic wr, input logic [2:0] f3, input logic [31:0] addr);
    return mk(wr, f3, addr, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat, ncs, explat;
    logic [3:0]  cbe;
    logic [31:0] cad, cdo;
    logic        cwen, stray;
    lat = 0; ncs = 0; cbe = 4'h0; cad = 32'h0; cdo = 32'h0; cwen = 1'b1; stray = 1'b0;
    @(negedge CLK);
    chk($sformatf("v%0d_ready", idx), {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = v.wr; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata; D_MEM_DI = v.di;
    @(posedge CLK);
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge CLK);
      req_valid = 1'b0;
      if (D_MEM_CSN == 1'b0) begin
        ncs++; cbe = D_MEM_BE; cad = D_MEM_ADDR; cdo = D_MEM_DOUT; cwen = D_MEM_WEN;
      end else if (D_MEM_BE != 4'h0 || D_MEM_WEN == 1'b0) begin
        stray = 1'b1;
      end
      if (rsp_valid) lat = k;
    end
    explat = v.err ? 1 : (v.wr ? 2 : 2 + W);
    chk($sformatf("v%0d_latency", idx), lat, explat);
    chk($sformatf("v%0d_strobes", idx), ncs, v.acc);
    chk($sformatf("v%0d_idle_lines", idx), {31'd0, stray}, 32'd0);
    chk($sformatf("v%0d_err", idx), {31'd0, rsp_err}, {31'd0, v.err});
    chk($sformatf("v%0d_rdata", idx), rsp_rdata, v.rdata);
    chk($sformatf("v%0d_busy", idx), {31'd0, req_ready}, 32'd0);
    if (v.acc != 0) begin
      chk($sformatf("v%0d_be", idx), {28'd0, cbe}, {28'd0, v.be});
      chk($sformatf("v%0d_addr", idx), cad, v.maddr);
      chk($sformatf("v%0d_wen", idx), {31'd0, cwen}, {31'd0, ~v.wr});
      if (v.wr) chk($sformatf("v%0d_dout", idx), cdo, v.dout);
    end
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    chk($sformatf("v%0d_rsp_drop", idx), {31'd0, rsp_valid}, 32'd0);
    chk($sformatf("v%0d_ready_back", idx), {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t expected=finish", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    RST = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; D_MEM_DI = 32'h0; rsp_ready = 1'b0;

    vecs[0]  = mk(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1, 4'hF, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0);
    vecs[1]  = mk(1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1, 4'h8, 32'h100, 32'hA5A5A5A5, 32'h0, 1'b0);
    vecs[2]  = mk(1'b0, 3'b000, 32'h103, 32'h0, 32'hA5000000, 1, 4'h8, 32'h100, 32'h0, 32'hFFFFFFA5, 1'b0);
    vecs[3]  = mk(1'b0, 3'b100, 32'h103, 32'h0, 32'hA5000000, 1, 4'h8, 32'h100, 32'h0, 32'h000000A5, 1'b0);
    vecs[4]  = mk(1'b0, 3'b001, 32'h102, 32'h0, 32'h80010000, 1, 4'hC, 32'h100, 32'h0, 32'hFFFF8001, 1'b0);
    vecs[5]  = mk(1'b0, 3'b101, 32'h102, 32'h0, 32'h80010000, 1, 4'hC, 32'h100, 32'h0, 32'h00008001, 1'b0);
    vecs[6]  = mk(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 1, 4'hC, 32'h200, 32'hABCDABCD, 32'h0, 1'b0);
    vecs[7]  = mk(1'b0, 3'b010, 32'h104, 32'h0, 32'h13579BDF, 1, 4'hF, 32'h104, 32'h0, 32'h13579BDF, 1'b0);
    vecs[8]  = mk(1'b0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 1, 4'h2, 32'h100, 32'h0, 32'h0000007F, 1'b0);
    vecs[9]  = mk_fault(1'b0, 3'b011, 32'h100);
    vecs[10] = mk_fault(1'b1, 3'b011, 32'h100);
    vecs[11] = TRAP ? mk_fault(1'b0, 3'b010, 32'h101)
                    : mk(1'b0, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, 1, 4'hF, 32'h100, 32'h0, 32'hCAFEF00D, 1'b0);
    vecs[12] = TRAP ? mk_fault(1'b0, 3'b001, 32'h103)
                    : mk(1'b0, 3'b001, 32'h103, 32'h0, 32'h80010000, 1, 4'hC, 32'h100, 32'h0, 32'hFFFF8001, 1'b0);
    vecs[13] = TRAP ? mk_fault(1'b1, 3'b010, 32'h306)
                    : mk(1'b1, 3'b010, 32'h306, 32'h55AA55AA, 32'h0, 1, 4'hF, 32'h304, 32'h55AA55AA, 32'h0, 1'b0);
    vecs[14] = mk_fault(1'b0, 3'b110, 32'h100);

    // Reset values.
    repeat (2) @(negedge CLK);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_csn", {31'd0, D_MEM_CSN}, 32'd1);
    chk("rst_wen", {31'd0, D_MEM_WEN}, 32'd1);
    chk("rst_be", {28'd0, D_MEM_BE}, 32'd0);
    chk("rst_addr", D_MEM_ADDR, 32'h0);
    chk("rst_dout", D_MEM_DOUT, 32'h0);
    RST = 1'b0;

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Response held under back-pressure for four cycles.
    begin
      int lat;
      lat = 0;
      @(negedge CLK);
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b001; req_addr = 32'h102; D_MEM_DI = 32'h80010000;
      @(posedge CLK);
      for (int k = 1; k <= 40 && lat == 0; k++) begin
        @(negedge CLK);
        req_valid = 1'b0;
        if (rsp_valid) lat = k;
      end
      chk("stall_latency", lat, 2 + W);
      req_valid = 1'b1;
      D_MEM_DI = 32'h00000000;
      for (int k = 0; k < 4; k++) begin
        @(negedge CLK);
        chk($sformatf("stall%0d_valid", k), {31'd0, rsp_valid}, 32'd1);
        chk($sformatf("stall%0d_rdata", k), rsp_rdata, 32'hFFFF8001);
        chk($sformatf("stall%0d_ready", k), {31'd0, req_ready}, 32'd0);
        chk($sformatf("stall%0d_csn", k), {31'd0, D_MEM_CSN}, 32'd1);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge CLK);
      rsp_ready = 1'b0;
      chk("stall_release", {31'd0, rsp_valid}, 32'd0);
    end

    // Reset pulse while waiting on read data abandons the load.
    @(negedge CLK);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; D_MEM_DI = 32'h11111111;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("rstwait_async_ready", {31'd0, req_ready}, 32'd1);
    chk("rstwait_async_csn", {31'd0, D_MEM_CSN}, 32'd1);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rstwait_ready", {31'd0, req_ready}, 32'd1);
    chk("rstwait_valid", {31'd0, rsp_valid}, 32'd0);
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
        @(negedge CLK);
        if (rsp_valid || !D_MEM_CSN) seen = 1'b1;
      end
      chk("rstwait_no_rsp", {31'd0, seen}, 32'd0);
    end

    run_vec(100, vecs[7]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
